// File: rtl/key_pulse.sv
// ============================================================================
//  Module   : key_pulse
//  Purpose  : Synchronise and debounce an active-low pushbutton, then emit one
//             count-enable pulse per press plus auto-repeat pulses while held.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module key_pulse #(
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int RPT_CYCLES  = 3,
  parameter int CNT_W       = 8
) (
  input  logic ck,
  input  logic rs,
  input  logic key_n,
  output logic pulse,
  output logic level,
  output logic rpt
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_DB_PRESS   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_DB_RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] C_DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_RPT_LAST  = CNT_W'(RPT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic             C_HOLD_EN   = (HOLD_CYCLES != 0);
  localparam logic             C_DB_ONE    = (DB_CYCLES == 1);

  logic             r_s1;
  logic             r_s2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_level;
  logic             r_rpt;

  logic             w_key_s;
  logic             w_db_done;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [1:0]       w_state;
  logic [CNT_W-1:0] w_cnt;
  logic             w_pulse;
  logic             w_level;
  logic             w_rpt;

  assign w_key_s = ~r_s2;

  // Debounce windows are entered with cnt = 1, so a single-sample window
  // accepts on the very first edge spent inside it.
  assign w_db_done = C_DB_ONE || (r_cnt == C_DB_LAST);

  // Saturating increment keeps the hold timer parked when repeat is disabled.
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + C_CNT_ONE;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_pulse = 1'b0;
    w_level = r_level;
    w_rpt   = r_rpt;
    case (r_state)
      ST_IDLE: begin
        if (w_key_s) begin
          w_state = ST_DB_PRESS;
          w_cnt   = C_CNT_ONE;
        end
      end
      ST_DB_PRESS: begin
        if (!w_key_s) begin
          w_state = ST_IDLE;
        end else if (w_db_done) begin
          w_state = ST_HELD;
          w_pulse = 1'b1;
          w_level = 1'b1;
          w_cnt   = '0;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      ST_HELD: begin
        if (!w_key_s) begin
          w_state = ST_DB_RELEASE;
          w_cnt   = C_CNT_ONE;
          w_rpt   = 1'b0;
        end else if (C_HOLD_EN && !r_rpt && (r_cnt == C_HOLD_LAST)) begin
          w_pulse = 1'b1;
          w_rpt   = 1'b1;
          w_cnt   = '0;
        end else if (r_rpt && (r_cnt == C_RPT_LAST)) begin
          w_pulse = 1'b1;
          w_cnt   = '0;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      ST_DB_RELEASE: begin
        if (w_key_s) begin
          w_state = ST_HELD;
          w_cnt   = '0;
        end else if (w_db_done) begin
          w_state = ST_IDLE;
          w_level = 1'b0;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_cnt   = '0;
        w_level = 1'b0;
        w_rpt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
      r_rpt   <= 1'b0;
    end else begin
      r_s1    <= key_n;
      r_s2    <= r_s1;
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_pulse <= w_pulse;
      r_level <= w_level;
      r_rpt   <= w_rpt;
    end
  end

  assign pulse = r_pulse;
  assign level = r_level;
  assign rpt   = r_rpt;

endmodule

`default_nettype wire

// File: tb/tb_key_pulse.sv
// ============================================================================
//  Module   : tb_key_pulse
//  Purpose  : Directed, table-driven self-checking bench for key_pulse.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_pulse;

  logic ck;
  logic rs;
  logic key_n;
  logic pulse;
  logic level;
  logic rpt;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic key_n;
    logic pulse;
    logic level;
    logic rpt;
  } vec_t;

  vec_t vecs[$];

  key_pulse #(
    .DB_CYCLES  (4),
    .HOLD_CYCLES(8),
    .RPT_CYCLES (3),
    .CNT_W      (8)
  ) dut (
    .ck   (ck),
    .rs   (rs),
    .key_n(key_n),
    .pulse(pulse),
    .level(level),
    .rpt  (rpt)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  function automatic logic [63:0] rng(input int a, input int b);
    logic [63:0] m;
    m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bitm(input int n);
    logic [63:0] m;
    m = '0;
    m[n] = 1'b1;
    return m;
  endfunction

  // One record per edge E0..E(len-1); masks hold the key_n low cycles and
  // the cycles in which each output is expected high.
  task automatic add_scn(input int len, input logic [63:0] low_m, input logic [63:0] pul_m,
                         input logic [63:0] lev_m, input logic [63:0] rpt_m);
    vec_t v;
    for (int i = 0; i < len; i++) begin
      v.key_n = ~low_m[i];
      v.pulse = pul_m[i];
      v.level = lev_m[i];
      v.rpt   = rpt_m[i];
      vecs.push_back(v);
    end
  endtask

  // Key held low across reset release: first pulse on the 6th edge, first repeat 8 later.
  task automatic press_from_reset(input string tag);
    for (int e = 0; e <= 13; e++) begin
      tick();
      chk({tag, "_pulse"}, pulse, (e == 5) || (e == 13));
      chk({tag, "_level"}, level, (e >= 5));
      chk({tag, "_rpt"},   rpt,   (e >= 13));
    end
  endtask

  initial begin
    rs    = 1'b1;
    key_n = 1'b1;
    tick();
    tick();

    // Scenario 1: async reset with key pressed, then sync + debounce latency.
    #2 rs = 1'b0;
    key_n = 1'b0;
    #1;
    chk("rst_pulse", pulse, 1'b0);
    chk("rst_level", level, 1'b0);
    chk("rst_rpt",   rpt,   1'b0);
    tick();
    tick();
    chk("rst_hold_level", level, 1'b0);
    rs = 1'b1;
    press_from_reset("s1");

    // Scenario 6: reset mid-repeat clears outputs before the next edge.
    tick();
    #2 rs = 1'b0;
    #1;
    chk("s6_async_pulse", pulse, 1'b0);
    chk("s6_async_level", level, 1'b0);
    chk("s6_async_rpt",   rpt,   1'b0);
    tick();
    tick();
    rs = 1'b1;
    press_from_reset("s6");

    key_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("s6_idle_level", level, 1'b0);
    chk("s6_idle_rpt",   rpt,   1'b0);

    // Scenario 2: clean press, low E0..E6.
    add_scn(16, rng(0, 6), bitm(5), rng(5, 11), '0);
    // Scenario 3: press bounce.
    add_scn(14, rng(0, 2) | rng(5, 6), '0, '0, '0);
    // Scenario 4: hold with auto-repeat, low E0..E24.
    add_scn(35, rng(0, 24),
            bitm(5) | bitm(13) | bitm(16) | bitm(19) | bitm(22) | bitm(25),
            rng(5, 29), rng(13, 26));
    // Scenario 5: release bounce at E10..E11 restarts the hold timer.
    add_scn(33, rng(0, 9) | rng(12, 22), bitm(5) | bitm(22), rng(5, 27), rng(22, 24));

    foreach (vecs[i]) begin
      key_n = vecs[i].key_n;
      tick();
      chk($sformatf("vec%0d_pulse", i), pulse, vecs[i].pulse);
      chk($sformatf("vec%0d_level", i), level, vecs[i].level);
      chk($sformatf("vec%0d_rpt",   i), rpt,   vecs[i].rpt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
